fifo_pack_flush: RTL and testbench
==================================

FIFO_PACK_FLUSH -- requirements
Module: fifo_pack_flush

Interface
REQ-001 Parameter DATA_W, default 4, width of one entry in bits.
REQ-002 Parameter DEPTH, default 32, entry count; SHALL be a power of two, at least 2.
REQ-003 Parameter LANES, default 8, entries packed per output beat; SHALL be at most DEPTH.
REQ-004 Parameter PAD_VAL, default 4'hC (DATA_W bits), fill value for unused lanes.
REQ-005 clk  in  1  single clock; all state on posedge clk.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_valid_i  in  1  write request.
REQ-008 wr_data_i  in  DATA_W  write entry.
REQ-009 wr_ready_o  out  1  equals !full_o.
REQ-010 flush_i  in  1  level input; a rising edge requests a flush.
REQ-011 rd_valid_o  out  1  output beat valid.
REQ-012 rd_ready_i  in  1  output beat accepted when high together with rd_valid_o.
REQ-013 rd_data_o  out  LANES*DATA_W  packed beat; lane k is bits [k*DATA_W +: DATA_W]; lane 0 is the oldest entry.
REQ-014 rd_count_o  out  $clog2(LANES+1)  number of real entries in the beat.
REQ-015 rd_last_o  out  1  final beat of the current flush.
REQ-016 flush_done_o  out  1  one-cycle pulse when the flush completes.
REQ-017 empty_o / full_o  out  1 each  level==0 / level==DEPTH.
REQ-018 level_o  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-019 Write pointer, read pointer and level SHALL wrap modulo DEPTH, using one extra pointer bit to separate full from empty.
REQ-020 A write with wr_valid_i high and full_o low SHALL store the entry at the write pointer and increment it; a write while full SHALL be dropped with no state change.
REQ-021 The FSM SHALL have the states IDLE, DRAIN and DONE.
REQ-022 IDLE: a rising edge of flush_i (flush_i=1, previous sample 0) sampled at edge N SHALL snapshot remaining=level_o.
  - If remaining is 0: go to DONE.
  - Otherwise: load the first beat into the output register and go to DRAIN; rd_valid_o is high from cycle N+1.
REQ-023 Beat contents SHALL be: lane k = entry[rd_ptr+k] when k < min(remaining, LANES), else PAD_VAL; rd_count_o = min(remaining, LANES); rd_last_o = (remaining <= LANES).
REQ-024 DRAIN: rd_data_o, rd_count_o and rd_last_o SHALL hold stable while rd_valid_o is high and rd_ready_i is low.
REQ-025 On accept, rd_ptr SHALL advance by rd_count_o and remaining SHALL decrease by rd_count_o.
  - If not last: load the next beat on the same edge (back-to-back, no bubble).
  - If last: drop rd_valid_o and go to DONE.
REQ-026 DONE: flush_done_o SHALL be high for exactly one cycle, then the FSM returns to IDLE.
REQ-027 Writes during DRAIN/DONE SHALL be accepted and retained for a later flush; they are excluded from the snapshot.
REQ-028 A write and a pop on the same edge SHALL both take effect: level += 1 - rd_count_o.
REQ-029 Rising edges of flush_i outside IDLE SHALL be ignored; flush_i held high SHALL NOT retrigger.
REQ-030 rd_data_o SHALL hold its last value while rd_valid_o is low.

Reset
REQ-031 reset low SHALL immediately clear:
  - pointers, level, remaining, flush-edge history and storage contents to 0;
  - the FSM to IDLE;
  - rd_valid_o, rd_data_o, rd_count_o, rd_last_o and flush_done_o to 0.
  Resulting outputs: empty_o=1, full_o=0, wr_ready_o=1.
REQ-032 Reset mid-DRAIN SHALL abandon the flush with no flush_done_o pulse.

Structure
REQ-033 A shared package fifo_flush_pkg SHALL hold the FSM state enum and the default PAD_VAL constant.
REQ-034 The packing/padding logic SHALL be one sub-module, lane_packer, that is combinational and parametrised by DATA_W and LANES.

Verification (defaults)
REQ-035 Write 1,2,3,4,5, then flush with rd_ready_i=1 -> one beat 0xCCC54321, count 5, last=1; flush_done_o pulses the next cycle; empty_o=1.
REQ-036 Write 20 entries 0..F,0..3, then flush -> beats 0x76543210/8, 0xFEDCBA98/8, 0xCCCC3210/4 (last) on consecutive cycles.
REQ-037 Same as REQ-036 with rd_ready_i low for 3 cycles on beat 2 -> 0xFEDCBA98 held stable and level_o unchanged until accept.
REQ-038 Write 33 entries -> full_o=1 after the 32nd, the 33rd is dropped, level_o=32; after flush the beats hold entries 1..32 only.
REQ-039 Flush of 3 entries while writing 2 more during DRAIN -> beat count 3; afterwards level_o=2; flush when empty -> no beat, flush_done_o pulses at N+1.
REQ-040 Assert reset during beat 2 of REQ-036 -> all outputs return to reset values immediately and no flush_done_o pulse occurs.

Source files
------------

// File: rtl/fifo_flush_pkg.sv
// Shared FSM state encoding and default pad value for the packing flush FIFO.
package fifo_flush_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } flush_state_e;

    localparam logic [3:0] PAD_VAL_DEFAULT = 4'hC;

endpackage

// File: rtl/fifo_pack_flush_if.sv
// Write, flush and packed-read signals of the flush FIFO, bundled for the port list.
interface fifo_pack_flush_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 32,
    parameter int LANES  = 8
);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                      wr_valid_i;
    logic [DATA_W-1:0]         wr_data_i;
    logic                      wr_ready_o;
    logic                      flush_i;
    logic                      rd_valid_o;
    logic                      rd_ready_i;
    logic [LANES*DATA_W-1:0]   rd_data_o;
    logic [CNT_W-1:0]          rd_count_o;
    logic                      rd_last_o;
    logic                      flush_done_o;
    logic                      empty_o;
    logic                      full_o;
    logic [LVL_W-1:0]          level_o;

    modport master (
        output wr_valid_i, wr_data_i, flush_i, rd_ready_i,
        input  wr_ready_o, rd_valid_o, rd_data_o, rd_count_o, rd_last_o,
               flush_done_o, empty_o, full_o, level_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, flush_i, rd_ready_i,
        output wr_ready_o, rd_valid_o, rd_data_o, rd_count_o, rd_last_o,
               flush_done_o, empty_o, full_o, level_o
    );

endinterface

// File: rtl/fifo_pack_flush_lane_packer.sv
// Combinational beat packer: keeps the first count lanes, fills the rest with PAD_VAL.
module lane_packer #(
    parameter int                 DATA_W  = 4,
    parameter int                 LANES   = 8,
    parameter logic [DATA_W-1:0]  PAD_VAL = '0,
    localparam int                CNT_W   = $clog2(LANES + 1)
) (
    input  logic [LANES*DATA_W-1:0] entries,
    input  logic [CNT_W-1:0]        count,
    output logic [LANES*DATA_W-1:0] beat
);

    always_comb begin
        beat = '0;
        for (int k = 0; k < LANES; k++) begin
            if (CNT_W'(k) < count)
                beat[k*DATA_W +: DATA_W] = entries[k*DATA_W +: DATA_W];
            else
                beat[k*DATA_W +: DATA_W] = PAD_VAL;
        end
    end

endmodule

// File: rtl/fifo_pack_flush.sv
// Circular FIFO that, on a flush edge, drains its snapshot occupancy as packed multi-lane beats.
//
//   state | meaning
//   IDLE  | accepting writes, watching for a flush_i rising edge
//   DRAIN | presenting packed beats until the last one is accepted
//   DONE  | one-cycle flush_done pulse, then back to IDLE
module fifo_pack_flush
    import fifo_flush_pkg::*;
#(
    parameter int                 DATA_W  = 4,
    parameter int                 DEPTH   = 32,
    parameter int                 LANES   = 8,
    parameter logic [DATA_W-1:0]  PAD_VAL = DATA_W'(PAD_VAL_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    fifo_pack_flush_if.slave   bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(LANES + 1);

    flush_state_e state, state_nxt;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr, level, remaining;
    logic                    flush_q;
    logic [LANES*DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]        rd_count;
    logic                    rd_last;

    logic                    full, empty, wr_en, flush_rise;
    logic                    pop, load, rd_valid, flush_done;
    logic [ADDR_W-1:0]       src_addr;
    logic [PTR_W-1:0]        src_rem;
    logic [CNT_W-1:0]        nxt_count;
    logic                    nxt_last;
    logic [LANES*DATA_W-1:0] gathered, packed_beat;

    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == PTR_W'(DEPTH));
    assign empty      = (level == '0);
    assign wr_en      = bus.wr_valid_i && !full;
    assign flush_rise = bus.flush_i && !flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_rise) state_nxt = empty ? DONE : DRAIN;
            DRAIN:   if (pop && rd_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_valid   = (state == DRAIN);
        flush_done = (state == DONE);
        pop        = rd_valid && bus.rd_ready_i;
        load       = ((state == IDLE) && flush_rise && !empty) || (pop && !rd_last);
    end

    // A beat loaded on accept starts where the accepted beat ends.
    always_comb begin
        if (state == DRAIN) begin
            src_addr = rd_ptr[ADDR_W-1:0] + ADDR_W'(rd_count);
            src_rem  = remaining - PTR_W'(rd_count);
        end else begin
            src_addr = rd_ptr[ADDR_W-1:0];
            src_rem  = level;
        end
        nxt_last  = (src_rem <= PTR_W'(LANES));
        nxt_count = nxt_last ? CNT_W'(src_rem) : CNT_W'(LANES);
    end

    always_comb begin
        gathered = '0;
        for (int k = 0; k < LANES; k++)
            gathered[k*DATA_W +: DATA_W] = mem[src_addr + ADDR_W'(k)];
    end

    lane_packer #(
        .DATA_W  (DATA_W),
        .LANES   (LANES),
        .PAD_VAL (PAD_VAL)
    ) u_lane_packer (
        .entries (gathered),
        .count   (nxt_count),
        .beat    (packed_beat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            flush_q   <= 1'b0;
            rd_data   <= '0;
            rd_count  <= '0;
            rd_last   <= 1'b0;
        end else begin
            flush_q <= bus.flush_i;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(rd_count);
            if (load) begin
                remaining <= src_rem;
                rd_data   <= packed_beat;
                rd_count  <= nxt_count;
                rd_last   <= nxt_last;
            end else if (pop) begin
                remaining <= '0;
            end
        end
    end

    assign bus.wr_ready_o   = !full;
    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.level_o      = level;
    assign bus.rd_valid_o   = rd_valid;
    assign bus.rd_data_o    = rd_data;
    assign bus.rd_count_o   = rd_count;
    assign bus.rd_last_o    = rd_last;
    assign bus.flush_done_o = flush_done;

endmodule

// File: tb/tb_fifo_pack_flush.sv
// Scoreboard bench for fifo_pack_flush at default parameters.
module tb_fifo_pack_flush;
    import fifo_flush_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          cnt;
        bit          last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    fifo_pack_flush_if #(.DATA_W(4), .DEPTH(32), .LANES(8)) bus ();

    fifo_pack_flush dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    beat_t       exp_q[$];
    logic [3:0]  model[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.flush_done_o === 1'b1) done_cnt++;
        if (bus.rd_valid_o === 1'b1 && bus.rd_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data",  bus.rd_data_o, e.data);
                chk("beat_count", bus.rd_count_o, e.cnt);
                chk("beat_last",  bus.rd_last_o, e.last);
            end
        end
    end

    task automatic write_entry(input logic [3:0] d);
        if (model.size() < 32) model.push_back(d);
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = d;
        @(posedge clk); #1;
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic start_flush(input int hold);
        int rem;
        rem = model.size();
        while (rem > 0) begin
            beat_t b;
            b.cnt  = (rem > 8) ? 8 : rem;
            b.last = (rem <= 8);
            b.data = '0;
            for (int k = 0; k < 8; k++)
                b.data[k*4 +: 4] = (k < b.cnt) ? model.pop_front() : 4'hC;
            exp_q.push_back(b);
            rem -= b.cnt;
        end
        bus.flush_i = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.flush_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, done_cnt - start, 1);
    endtask

    initial begin
        logic [31:0] held;
        int          lvl_held;
        int          d0;

        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.flush_i    = 1'b0;
        bus.rd_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty",    bus.empty_o, 1);
        chk("rst_full",     bus.full_o, 0);
        chk("rst_wr_ready", bus.wr_ready_o, 1);
        chk("rst_level",    bus.level_o, 0);
        chk("rst_valid",    bus.rd_valid_o, 0);
        chk("rst_data",     bus.rd_data_o, 0);
        chk("rst_done",     bus.flush_done_o, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // five entries, single padded beat
        for (int i = 1; i <= 5; i++) write_entry(4'(i));
        chk("r35_level", bus.level_o, 5);
        start_flush(1);
        chk("r35_valid", bus.rd_valid_o, 1);
        chk("r35_data",  bus.rd_data_o, 32'hCCC54321);
        chk("r35_count", bus.rd_count_o, 5);
        chk("r35_last",  bus.rd_last_o, 1);
        @(posedge clk); #1;
        chk("r35_done",      bus.flush_done_o, 1);
        chk("r35_valid_off", bus.rd_valid_o, 0);
        @(posedge clk); #1;
        chk("r35_done_off",  bus.flush_done_o, 0);
        chk("r35_empty",     bus.empty_o, 1);
        chk("r35_hold_data", bus.rd_data_o, 32'hCCC54321);

        // twenty entries, three back-to-back beats
        for (int i = 0; i < 20; i++) write_entry(4'(i));
        start_flush(1);
        chk("r36_b1_data", bus.rd_data_o, 32'h76543210);
        @(posedge clk); #1;
        chk("r36_b2_valid", bus.rd_valid_o, 1);
        chk("r36_b2_data",  bus.rd_data_o, 32'hFEDCBA98);
        @(posedge clk); #1;
        chk("r36_b3_valid", bus.rd_valid_o, 1);
        chk("r36_b3_data",  bus.rd_data_o, 32'hCCCC3210);
        @(posedge clk); #1;
        chk("r36_done",  bus.flush_done_o, 1);
        chk("r36_empty", bus.empty_o, 1);

        // backpressure on beat 2
        for (int i = 0; i < 20; i++) write_entry(4'(i));
        start_flush(1);
        @(posedge clk); #1;
        bus.rd_ready_i = 1'b0;
        held = bus.rd_data_o;
        lvl_held = bus.level_o;
        chk("r37_level_b2", lvl_held, 12);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("r37_valid_hold", bus.rd_valid_o, 1);
            chk("r37_data_hold",  bus.rd_data_o, 32'hFEDCBA98);
            chk("r37_count_hold", bus.rd_count_o, 8);
            chk("r37_level_hold", bus.level_o, lvl_held);
        end
        bus.rd_ready_i = 1'b1;
        wait_done("r37_done");
        chk("r37_empty", bus.empty_o, 1);

        // overfill: 33rd write dropped
        for (int i = 1; i <= 33; i++) begin
            write_entry(4'(i));
            if (i == 31) chk("r38_not_full_31", bus.full_o, 0);
            if (i == 32) chk("r38_full_32", bus.full_o, 1);
        end
        chk("r38_level",    bus.level_o, 32);
        chk("r38_wr_ready", bus.wr_ready_o, 0);
        start_flush(1);
        wait_done("r38_done");
        chk("r38_empty", bus.empty_o, 1);

        // writes during drain are retained
        bus.rd_ready_i = 1'b0;
        write_entry(4'h7); write_entry(4'h8); write_entry(4'h9);
        start_flush(1);
        write_entry(4'hA); write_entry(4'hB);
        bus.rd_ready_i = 1'b1;
        wait_done("r39_done");
        chk("r39_level", bus.level_o, 2);
        start_flush(1);
        wait_done("r39_drain2_done");
        chk("r39_empty", bus.empty_o, 1);
        start_flush(1);
        chk("r39_empty_done",  bus.flush_done_o, 1);
        chk("r39_empty_valid", bus.rd_valid_o, 0);
        @(posedge clk); #1;
        chk("r39_empty_done_off", bus.flush_done_o, 0);

        // flush held high does not retrigger
        write_entry(4'h5);
        d0 = done_cnt;
        start_flush(12);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("hold_one_done", done_cnt - d0, 1);
        chk("hold_valid",    bus.rd_valid_o, 0);

        // reset mid-drain
        for (int i = 0; i < 20; i++) write_entry(4'(i));
        start_flush(1);
        @(posedge clk); #1;
        chk("r40_b2_valid", bus.rd_valid_o, 1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("r40_valid", bus.rd_valid_o, 0);
        chk("r40_data",  bus.rd_data_o, 0);
        chk("r40_count", bus.rd_count_o, 0);
        chk("r40_last",  bus.rd_last_o, 0);
        chk("r40_empty", bus.empty_o, 1);
        chk("r40_level", bus.level_o, 0);
        chk("r40_wr_ready", bus.wr_ready_o, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("r40_no_done", done_cnt - d0, 0);
        chk("r40_idle_valid", bus.rd_valid_o, 0);

        chk("scoreboard_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
